// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - base tick divider with four periodic channels and a round-robin event offer port
module tick_scheduler #(
   parameter int unsigned TICK_DIV = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       cfg_we,
   input  logic [1:0] cfg_ch,
   input  logic [7:0] cfg_period,
   output logic       tick,
   output logic       ev_valid,
   output logic [1:0] ev_ch,
   input  logic       ev_ready,
   output logic [3:0] overrun
);

   localparam logic [31:0] LP_LAST = 32'(TICK_DIV - 1);

   typedef enum logic {S_IDLE, S_OFFER} state_t;

   logic [31:0] r_base_cnt;
   logic        r_tick;
   logic [7:0]  r_period [4];
   logic [7:0]  r_cd     [4];
   logic [3:0]  r_pending;
   logic [3:0]  r_overrun;
   state_t      r_state;
   logic [1:0]  r_ev_ch;
   logic [1:0]  r_last_grant;

   logic [3:0]  w_accept;
   logic [3:0]  w_expire;
   state_t      w_state_nx;
   logic [1:0]  w_ch_nx;
   logic [1:0]  w_lg_nx;
   logic        w_found;
   logic [1:0]  w_idx;

   assign tick     = r_tick;
   assign ev_valid = (r_state == S_OFFER);
   assign ev_ch    = r_ev_ch;
   assign overrun  = r_overrun;

   // Base divider: wraps at TICK_DIV-1 and emits a one-cycle tick; frozen while run is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base_cnt <= '0;
         r_tick     <= 1'b0;
      end else if (run) begin
         if (r_base_cnt == LP_LAST) begin
            r_base_cnt <= '0;
            r_tick     <= 1'b1;
         end else begin
            r_base_cnt <= r_base_cnt + 32'd1;
            r_tick     <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   // Per-channel acceptance and expiry; a cfg write to a channel suppresses its expiry that cycle.
   always_comb begin
      w_accept = '0;
      w_expire = '0;
      for (int c = 0; c < 4; c++) begin
         if ((r_state == S_OFFER) && ev_ready && (r_ev_ch == 2'(c)))
            w_accept[c] = 1'b1;
         if (r_tick && (r_period[c] != 8'd0) && !(cfg_we && (cfg_ch == 2'(c))) && (r_cd[c] <= 8'd1))
            w_expire[c] = 1'b1;
      end
   end

   // Channel state: period/countdown reload, pending set-over-clear, sticky overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 4; c++) begin
            r_period[c] <= '0;
            r_cd[c]     <= '0;
         end
         r_pending <= '0;
         r_overrun <= '0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (cfg_we && (cfg_ch == 2'(c))) begin
               r_period[c]  <= cfg_period;
               r_cd[c]      <= cfg_period;
               r_overrun[c] <= 1'b0;
            end else begin
               if (r_tick && (r_period[c] != 8'd0)) begin
                  if (r_cd[c] <= 8'd1)
                     r_cd[c] <= r_period[c];
                  else
                     r_cd[c] <= r_cd[c] - 8'd1;
               end
               if (w_expire[c] && r_pending[c] && !w_accept[c])
                  r_overrun[c] <= 1'b1;
            end
         end
         r_pending <= w_expire | (r_pending & ~w_accept);
      end
   end

   // Output FSM next state: round-robin pick from last_grant+1 in IDLE, hold offer until accepted.
   always_comb begin
      w_state_nx = r_state;
      w_ch_nx    = r_ev_ch;
      w_lg_nx    = r_last_grant;
      w_found    = 1'b0;
      w_idx      = '0;
      case (r_state)
         S_IDLE: begin
            for (int k = 1; k <= 4; k++) begin
               w_idx = r_last_grant + 2'(k);
               if (!w_found && r_pending[w_idx]) begin
                  w_found = 1'b1;
                  w_ch_nx = w_idx;
               end
            end
            if (w_found)
               w_state_nx = S_OFFER;
         end
         S_OFFER: begin
            if (ev_ready) begin
               w_state_nx = S_IDLE;
               w_lg_nx    = r_ev_ch;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Output FSM registers; reset abandons any offer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ev_ch      <= '0;
         r_last_grant <= 2'd3;
      end else begin
         r_state      <= w_state_nx;
         r_ev_ch      <= w_ch_nx;
         r_last_grant <= w_lg_nx;
      end
   end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1_000_000, meaning clk cycles per base tick (legal range 2..2^32-1).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port run  input  1  when high, the base tick counter advances.
REQ-005 SHALL have port cfg_we  input  1  one-cycle write strobe for a channel period.
REQ-006 SHALL have port cfg_ch  input  2  channel index for the write.
REQ-007 SHALL have port cfg_period  input  8  period in base ticks; 0 disables the channel.
REQ-008 SHALL have port tick  output  1  one-cycle pulse per base tick.
REQ-009 SHALL have port ev_valid  output  1  an event is offered.
REQ-010 SHALL have port ev_ch  output  2  channel of the offered event.
REQ-011 SHALL have port ev_ready  input  1  consumer accepts the offered event.
REQ-012 SHALL have port overrun  output  4  sticky per-channel flag: expiry lost while an event was still pending.

Function
REQ-013 SHALL keep a 32-bit base counter: with run=1, it increments each cycle; at TICK_DIV-1 it wraps to 0 and tick is registered high for exactly the next cycle.
REQ-014 SHALL hold the base counter and keep tick=0 while run=0; the event handshake continues.
REQ-015 SHALL keep per channel an 8-bit period register and an 8-bit countdown.
REQ-016 SHALL, on cfg_we, load period[cfg_ch] and countdown[cfg_ch] with cfg_period and clear overrun[cfg_ch]; pending[cfg_ch] is unaffected.
REQ-017 SHALL, on each tick with period!=0 and no same-cycle cfg write to that channel, do: countdown<=1 -> expire and reload countdown with period; else decrement countdown. Period P therefore gives one expiry every P ticks.
REQ-018 SHALL let a cfg write win over a same-cycle tick on the same channel: reload only, no expiry.
REQ-019 SHALL never expire a channel with period=0; its already-pending event still delivers.
REQ-020 SHALL, on expiry, set pending[ch]; if pending[ch] is already 1 and is not being accepted that cycle, set overrun[ch] and keep pending at 1.
REQ-021 SHALL, on expiry of a channel in the same cycle it is accepted, leave pending=1 (set wins over clear) and not flag overrun.
REQ-022 SHALL run an output FSM with states IDLE and OFFER.
REQ-023 SHALL, in IDLE with any pending set, pick a channel round-robin starting at last_grant+1 (mod 4), register ev_ch, assert ev_valid, and move to OFFER; otherwise stay in IDLE.
REQ-024 SHALL hold ev_valid=1 and ev_ch stable in OFFER until ev_valid&&ev_ready.
REQ-025 SHALL, on acceptance, clear pending[ev_ch] (subject to REQ-021), set last_grant=ev_ch, drop ev_valid next cycle, and return to IDLE, giving at most one event per 2 cycles.
REQ-026 SHALL ignore ev_ready while ev_valid=0.

Reset
REQ-027 SHALL, while rst_n=0 and independent of clk, force the base counter, tick, ev_valid, ev_ch, pending, overrun, periods and countdowns to 0, last_grant to 3 (channel 0 has first priority), and the FSM to IDLE.
REQ-028 SHALL abandon any in-flight offer on reset mid-operation; that event is lost and is not flagged as overrun.

Verification (TICK_DIV=4)
REQ-029 SHALL test: reset, then run=1 held -> tick high one cycle every 4 cycles, first pulse 4 cycles after run rises; run=0 for 10 cycles -> no tick, and the phase resumes unchanged.
REQ-030 SHALL test: ch0 period 2, ch1 period 3, ev_ready=1 -> ch0 events after ticks 2 and 4, ch1 after tick 3; at tick 6 both expire -> ch1 then ch0 (last_grant=0).
REQ-031 SHALL test: all four channels period 1, ev_ready=1 -> grants rotate 0,1,2,3,0..., each accepted event followed by one ev_valid=0 cycle.
REQ-032 SHALL test: ch2 period 1, ev_ready=0 -> ev_valid=1, ev_ch=2 stable; the next tick sets overrun=4'b0100; a cfg write to ch2 clears it; ev_ready=1 then delivers ch2.
REQ-033 SHALL test: cfg write to ch1 in the same cycle as a tick that would expire it -> no event; countdown reloaded.
REQ-034 SHALL test: rst_n low mid-OFFER -> ev_valid=0, overrun=0, pending=0 immediately, without waiting for a clk edge.
